// File: rtl/coin_payer_pkg.sv
// Shared encodings for the coin payer: FSM states, payment modes, coin types.
package coin_payer_pkg;

    // One-hot FSM state encoding.
    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_COIN      = 5'b00010,
        ST_GAP       = 5'b00100,
        ST_WAIT_RESP = 5'b01000,
        ST_DONE      = 5'b10000
    } state_e;

    // Payment patterns (price 2.5 units).
    typedef enum logic [1:0] {
        MODE_HHHHH = 2'b00,  // H,H,H,H,H
        MODE_OOH   = 2'b01,  // O,O,H
        MODE_OOO   = 2'b10,  // O,O,O -> half-unit change expected
        MODE_HOO   = 2'b11   // H,O,O
    } pay_mode_e;

    // Coin type driven in a COIN cycle.
    typedef enum logic {
        COIN_HALF = 1'b0,
        COIN_ONE  = 1'b1
    } coin_e;

    // Coin index width (up to five coins per purchase).
    localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/coin_payer_coin_seq_rom.sv
// Coin sequence table: (mode, index) -> coin type, last-coin flag, change expected.
module coin_seq_rom
    import coin_payer_pkg::*;
(
    input  pay_mode_e        mode_i,
    input  logic [IDX_W-1:0] idx_i,
    output coin_e            coin_o,
    output logic             last_o,
    output logic             exp_change_o
);

    // Pure lookup of the payment pattern.
    always_comb begin
        coin_o       = COIN_HALF;
        last_o       = 1'b0;
        exp_change_o = 1'b0;
        case (mode_i)
            MODE_HHHHH: begin
                coin_o = COIN_HALF;
                last_o = (idx_i == 3'd4);
            end
            MODE_OOH: begin
                coin_o = (idx_i < 3'd2) ? COIN_ONE : COIN_HALF;
                last_o = (idx_i == 3'd2);
            end
            MODE_OOO: begin
                coin_o       = COIN_ONE;
                last_o       = (idx_i == 3'd2);
                exp_change_o = 1'b1;
            end
            MODE_HOO: begin
                coin_o = (idx_i == 3'd0) ? COIN_HALF : COIN_ONE;
                last_o = (idx_i == 3'd2);
            end
            default: begin
                coin_o = COIN_HALF;
                last_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/coin_payer.sv
// Coin payer: feeds a 2.5-unit coin pattern to a vending machine and reports the outcome.
module coin_payer
    import coin_payer_pkg::*;
#(
    parameter int unsigned COIN_GAP     = 4,
    parameter int unsigned RESP_TIMEOUT = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pay_start,
    input  logic [1:0] pay_mode,
    input  logic       pi_cola,
    input  logic       pi_change,
    output logic       po_money_one,
    output logic       po_money_half,
    output logic       busy,
    output logic       done,
    output logic       cola_ok,
    output logic       change_ok,
    output logic       err_timeout
);

    localparam logic [3:0] GAP_LAST  = 4'(COIN_GAP - 1);
    localparam logic [7:0] RESP_LAST = 8'(RESP_TIMEOUT - 1);

    state_e           state_q, state_d;
    pay_mode_e        mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       gap_q, gap_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             cola_ok_q, cola_ok_d;
    logic             change_ok_q, change_ok_d;
    logic             err_q, err_d;
    logic             one_q, one_d;
    logic             half_q, half_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_q, exp_q;

    coin_e            rom_coin;
    logic             rom_last;
    logic             rom_exp;

    // The table is addressed with next-state mode/index so every output can be a flop;
    // last_q/exp_q therefore always describe the coin held in mode_q/idx_q.
    coin_seq_rom u_rom (
        .mode_i       (mode_d),
        .idx_i        (idx_d),
        .coin_o       (rom_coin),
        .last_o       (rom_last),
        .exp_change_o (rom_exp)
    );

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_HHHHH;
            idx_q       <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            cola_ok_q   <= 1'b0;
            change_ok_q <= 1'b0;
            err_q       <= 1'b0;
            one_q       <= 1'b0;
            half_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_q      <= 1'b0;
            exp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            cola_ok_q   <= cola_ok_d;
            change_ok_q <= change_ok_d;
            err_q       <= err_d;
            one_q       <= one_d;
            half_q      <= half_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            last_q      <= rom_last;
            exp_q       <= rom_exp;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        cola_ok_d   = cola_ok_q;
        change_ok_d = change_ok_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pay_start) begin
                    mode_d      = pay_mode_e'(pay_mode);
                    cola_ok_d   = 1'b0;
                    change_ok_d = 1'b0;
                    err_d       = 1'b0;
                    idx_d       = '0;
                    state_d     = ST_COIN;
                end
            end
            ST_COIN: begin
                if (last_q) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_RESP;
                end else begin
                    idx_d = idx_q + 3'd1;
                    if (COIN_GAP == 0) begin
                        state_d = ST_COIN;
                    end else begin
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_COIN;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            ST_WAIT_RESP: begin
                if (pi_cola) begin
                    cola_ok_d   = 1'b1;
                    change_ok_d = (pi_change == exp_q);
                    state_d     = ST_DONE;
                end else if (tmo_q == RESP_LAST) begin
                    err_d       = 1'b1;
                    cola_ok_d   = 1'b0;
                    change_ok_d = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        one_d  = (state_d == ST_COIN) && (rom_coin == COIN_ONE);
        half_d = (state_d == ST_COIN) && (rom_coin == COIN_HALF);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign po_money_one  = one_q;
    assign po_money_half = half_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cola_ok       = cola_ok_q;
    assign change_ok     = change_ok_q;
    assign err_timeout   = err_q;

endmodule

// File: doc/coin_payer.md
COIN_PAYER -- requirements
Module: coin_payer

Interface
REQ-001 Parameter COIN_GAP, default 4, idle cycles between consecutive coin pulses (legal 0..15).
REQ-002 Parameter RESP_TIMEOUT, default 8, max WAIT_RESP cycles for cola before error (legal 1..255).
REQ-003 sys_clk  in  1  single clock, all logic rising-edge.
REQ-004 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 pay_start  in  1  request one purchase; sampled only in IDLE.
REQ-006 pay_mode  in  2  payment pattern, latched with pay_start.
REQ-007 pi_cola  in  1  cola-dispensed pulse from vending machine.
REQ-008 pi_change  in  1  half-unit change pulse from vending machine.
REQ-009 po_money_one  out  1  one-unit coin pulse to vending machine.
REQ-010 po_money_half  out  1  half-unit coin pulse to vending machine.
REQ-011 busy  out  1  purchase in progress.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 cola_ok  out  1  cola received; valid from done until next accepted start.
REQ-014 change_ok  out  1  change received equals change expected for the mode; same validity.
REQ-015 err_timeout  out  1  no cola within RESP_TIMEOUT; same validity.

Function
REQ-016 Price is 2.5 units; modes SHALL issue coins in order: 00 = H,H,H,H,H; 01 = O,O,H; 10 = O,O,O (expects change); 11 = H,O,O.
REQ-017 States SHALL be IDLE, COIN, GAP, WAIT_RESP, DONE.
REQ-018 IDLE: pay_start=1 -> latch pay_mode, clear cola_ok/change_ok/err_timeout, coin index := 0, go COIN; else stay.
REQ-019 COIN: exactly one of po_money_one/po_money_half high for exactly this one cycle per coin; both never high together.
REQ-020 After COIN: if more coins remain and COIN_GAP>0 -> GAP for COIN_GAP cycles then COIN; if COIN_GAP=0 -> next COIN directly; if last coin -> WAIT_RESP with timeout counter := 0.
REQ-021 WAIT_RESP: pi_cola=1 -> cola_ok := 1, change_ok := (pi_change == expected), go DONE.
REQ-022 WAIT_RESP: counter reaches RESP_TIMEOUT without pi_cola -> err_timeout := 1, cola_ok := 0, change_ok := 0, go DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE.
REQ-024 busy SHALL be high from the cycle after pay_start acceptance through the done cycle inclusive.
REQ-025 pay_start while busy (including the done cycle) SHALL be ignored, not queued.
REQ-026 pi_cola/pi_change outside WAIT_RESP SHALL be ignored.
REQ-027 Coin outputs, done, and status outputs SHALL be registered (no combinational input-to-output path).
REQ-028 Latency (COIN_GAP=G): coin k (k from 0) drives in cycle 1+k*(G+1) after pay_start sample cycle 0; cola from a registered vending machine arrives in first WAIT_RESP cycle; done one cycle later.

Reset
REQ-029 sys_rst_n low SHALL immediately force state IDLE and all outputs 0, including mid-coin-pulse, GAP or WAIT_RESP; no partial sequence resumes after release.
REQ-030 First pay_start is accepted on the first rising edge with sys_rst_n high.

Structure
REQ-031 Shared package SHALL hold state encoding (one-hot, 5 bits), pay_mode encodings, and coin type constants (COIN_HALF, COIN_ONE).
REQ-032 Sub-module coin_seq_rom SHALL map (mode, index) to coin type, last-coin flag and expected-change flag; counters and FSM remain in coin_payer.

Verification
REQ-033 Bench SHALL pair coin_payer with the team's vending FSM and cover:
REQ-034 mode 01, G=4: start cycle 0 -> one@1, one@6, half@11, cola@12, done@13 with cola_ok=1, change_ok=1, err_timeout=0.
REQ-035 mode 10, G=0: one@1,2,3 -> cola and change@4, done@5, change_ok=1; mode 00 -> five half pulses, change_ok=1 with no change seen.
REQ-036 Vending machine disconnected (pi_cola tied 0), RESP_TIMEOUT=8 -> done exactly 8 cycles after WAIT_RESP entry, err_timeout=1, cola_ok=0.
REQ-037 pay_start held high continuously -> back-to-back purchases, second start accepted only in the IDLE cycle after done; no overlap of coin sequences.
REQ-038 sys_rst_n pulsed low during GAP of mode 00 -> all outputs 0 at once, busy low, no further coins until a new pay_start.
